// File: rtl/inv_sub_bytes_seq_if.sv
// Handshake bundle for inv_sub_bytes_seq: input state, substituted output state and status.
// fwd_sel exists only when SBOX_FWD_SHARE_EN is defined.
interface inv_sub_bytes_seq_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;
`ifdef SBOX_FWD_SHARE_EN
    logic         fwd_sel;
`endif

    modport master (
`ifdef SBOX_FWD_SHARE_EN
        output fwd_sel,
`endif
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
`ifdef SBOX_FWD_SHARE_EN
        input  fwd_sel,
`endif
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/inv_sub_bytes_seq.sv
// Iterative AES InvSubBytes over a 128-bit state using a GF((2^4)^2) tower inverter per lane.
// Define SBOX_FWD_SHARE_EN to add fwd_sel, which lets the same lanes compute the forward S-box.
module inv_sub_bytes_seq #(
    parameter int unsigned BYTES_PER_CYCLE = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    inv_sub_bytes_seq_if.slave  bus
);

    if (BYTES_PER_CYCLE != 1 && BYTES_PER_CYCLE != 2 && BYTES_PER_CYCLE != 4 &&
        BYTES_PER_CYCLE != 8 && BYTES_PER_CYCLE != 16) begin : g_bad_bpc
        $error("BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    localparam int unsigned NumChunks = 16 / BYTES_PER_CYCLE;
    localparam int unsigned CntW      = (NumChunks > 1) ? $clog2(NumChunks) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(NumChunks - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StBusy = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    // Tower: GF(2^4) mod x^4+x+1, extension Y^2 = Y + Lambda (irreducible since Tr(Lambda)=1).
    localparam logic [3:0] Lambda = 4'hE;

    function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p;
        logic [3:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[2:0], 1'b0} ^ (aa[3] ? 4'h3 : 4'h0);
        end
        return p;
    endfunction

    function automatic logic [3:0] gf16_inv(input logic [3:0] a);
        logic [3:0] a2, a4, a8;
        a2 = gf16_mul(a, a);
        a4 = gf16_mul(a2, a2);
        a8 = gf16_mul(a4, a4);
        return gf16_mul(gf16_mul(a2, a4), a8);
    endfunction

    function automatic logic [7:0] gfc_mul(input logic [7:0] p, input logic [7:0] q);
        logic [3:0] hh, hl, lh, ll;
        hh = gf16_mul(p[7:4], q[7:4]);
        hl = gf16_mul(p[7:4], q[3:0]);
        lh = gf16_mul(p[3:0], q[7:4]);
        ll = gf16_mul(p[3:0], q[3:0]);
        return {hh ^ hl ^ lh, gf16_mul(hh, Lambda) ^ ll};
    endfunction

    function automatic logic [7:0] lin_map(input logic [7:0] x, input logic [63:0] cols);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (x[i]) r = r ^ cols[i*8 +: 8];
        end
        return r;
    endfunction

    // Isomorphism columns are alpha^0..alpha^7 for a tower root alpha of x^8+x^4+x^3+x+1.
    function automatic logic [63:0] find_iso_cols();
        logic [63:0] cols, tmp;
        logic [7:0]  p, acc;
        logic        found;
        cols  = '0;
        found = 1'b0;
        for (int c = 2; c < 256; c++) begin
            if (!found) begin
                tmp      = '0;
                tmp[7:0] = 8'h01;
                p        = 8'h01;
                acc      = 8'h01;
                for (int e = 1; e <= 8; e++) begin
                    p = gfc_mul(p, 8'(c));
                    if (e < 8) tmp[e*8 +: 8] = p;
                    if (e == 1 || e == 3 || e == 4 || e == 8) acc = acc ^ p;
                end
                if (acc == 8'h00) begin
                    found = 1'b1;
                    cols  = tmp;
                end
            end
        end
        return cols;
    endfunction

    function automatic logic [63:0] find_inv_cols(input logic [63:0] fwd);
        logic [63:0] cols;
        cols = '0;
        for (int j = 0; j < 8; j++) begin
            for (int b = 0; b < 256; b++) begin
                if (lin_map(8'(b), fwd) == 8'(1 << j)) cols[j*8 +: 8] = 8'(b);
            end
        end
        return cols;
    endfunction

    localparam logic [63:0] IsoCols    = find_iso_cols();
    localparam logic [63:0] InvIsoCols = find_inv_cols(IsoCols);

    function automatic logic [7:0] inv_affine(input logic [7:0] x);
        return {x[1:0], x[7:2]} ^ {x[4:0], x[7:5]} ^ {x[6:0], x[7]};
    endfunction

    function automatic logic [7:0] gf256_inv(input logic [7:0] t);
        logic [7:0] g;
        logic [3:0] d, di;
        g  = lin_map(t, IsoCols);
        d  = gf16_mul(g[7:4], g[3:0]) ^ gf16_mul(g[3:0], g[3:0]) ^
             gf16_mul(Lambda, gf16_mul(g[7:4], g[7:4]));
        di = gf16_inv(d);
        return lin_map({gf16_mul(g[7:4], di), gf16_mul(g[3:0] ^ g[7:4], di)}, InvIsoCols);
    endfunction

`ifdef SBOX_FWD_SHARE_EN
    function automatic logic [7:0] fwd_affine(input logic [7:0] b);
        return b ^ {b[3:0], b[7:4]} ^ {b[4:0], b[7:5]} ^ {b[5:0], b[7:6]} ^ {b[6:0], b[7]} ^
               8'h63;
    endfunction

    function automatic logic [7:0] lane(input logic [7:0] x, input logic fwd);
        return fwd ? fwd_affine(gf256_inv(x)) : gf256_inv(inv_affine(x ^ 8'h63));
    endfunction
`else
    function automatic logic [7:0] lane(input logic [7:0] x);
        return gf256_inv(inv_affine(x ^ 8'h63));
    endfunction
`endif

    logic [1:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [127:0]    data_q, data_d;
    logic [127:0]    res_q, res_d;
`ifdef SBOX_FWD_SHARE_EN
    logic            fwd_q, fwd_d;
`endif

    always_comb begin
        int unsigned idx;
        idx     = 0;
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        res_d   = res_q;
`ifdef SBOX_FWD_SHARE_EN
        fwd_d   = fwd_q;
`endif
        case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    data_d  = bus.in_data;
                    cnt_d   = '0;
                    state_d = StBusy;
`ifdef SBOX_FWD_SHARE_EN
                    fwd_d   = bus.fwd_sel;
`endif
                end
            end
            StBusy: begin
                for (int unsigned k = 0; k < BYTES_PER_CYCLE; k++) begin
                    idx = int'(cnt_q) * BYTES_PER_CYCLE + k;
`ifdef SBOX_FWD_SHARE_EN
                    res_d[idx*8 +: 8] = lane(data_q[idx*8 +: 8], fwd_q);
`else
                    res_d[idx*8 +: 8] = lane(data_q[idx*8 +: 8]);
`endif
                end
                if (cnt_q == CntMax) begin
                    cnt_d   = '0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                if (bus.out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            data_q  <= '0;
            res_q   <= '0;
`ifdef SBOX_FWD_SHARE_EN
            fwd_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            res_q   <= res_d;
`ifdef SBOX_FWD_SHARE_EN
            fwd_q   <= fwd_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.busy      = (state_q == StBusy) || (state_q == StDone);
    assign bus.out_data  = res_q;

endmodule
